// File: rtl/hamming_encoder_proj_if.sv
// rtl/hamming_encoder_proj_if.sv - byte-in / codeword-out handshake bundle; err_inj/err_pos exist only with HAMMING_ERRINJ_EN
interface hamming_encoder_proj_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] io_out;
    logic       out_valid;
    logic       out_ready;
`ifdef HAMMING_ERRINJ_EN
    logic       err_inj;
    logic [2:0] err_pos;
`endif

    modport master (
        output in_data, in_valid, out_ready,
`ifdef HAMMING_ERRINJ_EN
        output err_inj, err_pos,
`endif
        input  in_ready, io_out, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef HAMMING_ERRINJ_EN
        input  err_inj, err_pos,
`endif
        output in_ready, io_out, out_valid
    );
endinterface

// File: rtl/hamming_encoder_proj.sv
// rtl/hamming_encoder_proj.sv - streaming Hamming(7,4) encoder, low nibble first; optional fault injection via HAMMING_ERRINJ_EN
module hamming_encoder_proj (
    input logic                   clk,
    input logic                   rst_n,
    hamming_encoder_proj_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    logic [1:0] state;
    logic [6:0] code_q;
    logic [3:0] hi_nib_q;   // low nibble is encoded at accept, so only the high half needs keeping
    logic       accept;
    logic [6:0] new_mask;
    logic [6:0] held_mask;

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

`ifdef HAMMING_ERRINJ_EN
    logic       inj_q;
    logic [2:0] pos_q;
    logic [7:0] new_shift;
    logic [7:0] held_shift;

    // Bit 7 of the shifted one falls outside the codeword, so err_pos = 7 injects nothing
    assign new_shift  = 8'd1 << bus.err_pos;
    assign held_shift = 8'd1 << pos_q;
    assign new_mask   = bus.err_inj ? new_shift[6:0] : 7'd0;
    assign held_mask  = inj_q ? held_shift[6:0] : 7'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
            pos_q <= 3'd0;
        end else if (accept) begin
            inj_q <= bus.err_inj;
            pos_q <= bus.err_pos;
        end
    end
`else
    assign new_mask  = 7'd0;
    assign held_mask = 7'd0;
`endif

    assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_HI) && bus.out_ready);
    assign bus.out_valid = (state == ST_LO) || (state == ST_HI);
    assign bus.io_out    = code_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            code_q   <= 7'd0;
            hi_nib_q <= 4'd0;
        end else if (accept) begin
            hi_nib_q <= bus.in_data[7:4];
            code_q   <= enc(bus.in_data[3:0]) ^ new_mask;
            state    <= ST_LO;
        end else begin
            case (state)
                ST_LO: if (bus.out_ready) begin
                    code_q <= enc(hi_nib_q) ^ held_mask;
                    state  <= ST_HI;
                end
                ST_HI: if (bus.out_ready) state <= ST_IDLE;
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_encoder_proj.sv
// tb/tb_hamming_encoder_proj.sv - self-checking bench for hamming_encoder_proj (vector table, corner sequences, random vs queue model)
module tb_hamming_encoder_proj;
    logic clk;
    logic rst_n;
    hamming_encoder_proj_if bus ();

    hamming_encoder_proj dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic [6:0] lo;
        logic [6:0] hi;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[11];
    logic [6:0] expq[$];

    // Generic Hamming rule: data fills non-power-of-two positions, parity p covers positions q with q & p
    function automatic logic [6:0] ref_enc(input logic [3:0] nib);
        logic [6:0] cw;
        int k;
        logic par;
        cw = '0;
        k = 0;
        for (int p = 1; p <= 7; p++)
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = nib[k];
                k++;
            end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int q = 1; q <= 7; q++)
                if (q != p && (q & p) != 0) par = par ^ cw[q-1];
            cw[p-1] = par;
        end
        return cw;
    endfunction

    function automatic int syndrome(input logic [6:0] cw);
        int s;
        s = 0;
        for (int q = 1; q <= 7; q++) if (cw[q-1]) s = s ^ q;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef HAMMING_ERRINJ_EN
        bus.err_inj = 1'b0;
        bus.err_pos = 3'd0;
`endif
    endtask

    task automatic one_byte(input string name, input logic [7:0] b, input logic [6:0] lo, input logic [6:0] hi);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check({name, " lo"}, {25'd0, bus.io_out}, {25'd0, lo});
        check({name, " lo valid"}, {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        #1;
        check({name, " hi"}, {25'd0, bus.io_out}, {25'd0, hi});
        @(negedge clk);
        #1;
        check({name, " done"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic rand_cycle();
        logic [6:0] mask;
        logic [7:0] sh;
        @(negedge clk);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.in_valid  = $urandom_range(0, 1);
        bus.in_data   = 8'($urandom);
        mask = 7'd0;
`ifdef HAMMING_ERRINJ_EN
        bus.err_inj = $urandom_range(0, 1);
        bus.err_pos = 3'($urandom);
        sh = 8'd1 << bus.err_pos;
        if (bus.err_inj) mask = sh[6:0];
`else
        sh = 8'd0;
`endif
        #1;
        check("rnd out_valid", {31'd0, bus.out_valid}, {31'd0, expq.size() != 0});
        check("rnd in_ready", {31'd0, bus.in_ready},
              {31'd0, (expq.size() == 0) || (expq.size() == 1 && bus.out_ready)});
        if (bus.out_valid && expq.size() != 0) begin
            check("rnd io_out", {25'd0, bus.io_out}, {25'd0, expq[0]});
            if (bus.out_ready) void'(expq.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
            expq.push_back(ref_enc(bus.in_data[3:0]) ^ mask);
            expq.push_back(ref_enc(bus.in_data[7:4]) ^ mask);
        end
    endtask

    initial begin
        logic [7:0] sbytes[4];
        logic [6:0] scodes[8];
        int idx;

        vecs[0] = '{8'h5B, 7'b1010101, 7'b0101101};
        vecs[1] = '{8'h00, 7'b0000000, 7'b0000000};
        vecs[2] = '{8'hFF, 7'b1111111, 7'b1111111};
        for (int i = 0; i < 8; i++) begin
            vecs[3+i].b  = {4'(2 * i + 1), 4'(2 * i)};
            vecs[3+i].lo = ref_enc(4'(2 * i));
            vecs[3+i].hi = ref_enc(4'(2 * i + 1));
        end

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset io_out", {25'd0, bus.io_out}, 32'd0);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            one_byte($sformatf("vec%0d", i), vecs[i].b, vecs[i].lo, vecs[i].hi);
            check("syndrome", syndrome(vecs[i].lo) + syndrome(vecs[i].hi), 32'd0);
        end

        // Backpressure: hold the low codeword for 5 cycles, then resume
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5B;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp hold", {25'd0, bus.io_out}, 32'h55);
            check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp lo", {25'd0, bus.io_out}, 32'h55);
        @(negedge clk);
        #1;
        check("bp hi", {25'd0, bus.io_out}, 32'h2D);
        @(negedge clk);
        #1;
        check("bp done", {31'd0, bus.out_valid}, 32'd0);

        // Streaming: 8 codewords on 8 consecutive cycles
        sbytes = '{8'h00, 8'hFF, 8'h5B, 8'hB5};
        for (int i = 0; i < 4; i++) begin
            scodes[2*i]   = ref_enc(sbytes[i][3:0]);
            scodes[2*i+1] = ref_enc(sbytes[i][7:4]);
        end
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid = (idx < 4);
            bus.in_data = (idx < 4) ? sbytes[idx] : 8'h00;
            #1;
            if (cyc >= 1 && cyc <= 8) begin
                check("stream valid", {31'd0, bus.out_valid}, 32'd1);
                check("stream code", {25'd0, bus.io_out}, {25'd0, scodes[cyc-1]});
            end
            if (cyc == 9) check("stream end", {31'd0, bus.out_valid}, 32'd0);
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid = 1'b0;

`ifdef HAMMING_ERRINJ_EN
        bus.err_inj = 1'b1;
        bus.err_pos = 3'd3;
        one_byte("inj3", 8'h0B, 7'b1011101, 7'b0001000);
        check("inj3 decoder", syndrome(7'b1011101) + syndrome(7'b0001000), 32'd8);
        bus.err_pos = 3'd7;
        one_byte("inj7", 8'h0B, ref_enc(4'hB), ref_enc(4'h0));
        bus.err_inj = 1'b0;
`endif

        // Asynchronous reset while the high codeword is pending
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5B;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre-rst valid", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst valid", {31'd0, bus.out_valid}, 32'd0);
        check("async rst io_out", {25'd0, bus.io_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);

        expq.delete();
        for (int i = 0; i < 600; i++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
